// File: rtl/wt_multiplier_pipe_pkg.sv
// Shared encodings, legal parameter ranges and tree-sizing helpers for the
// pipelined Wallace-tree multiplier.
package wt_multiplier_pipe_pkg;

  localparam bit MODE_UNSIGNED = 1'b0;
  localparam bit MODE_SIGNED   = 1'b1;

  localparam int WIDTH_MIN  = 4;
  localparam int WIDTH_MAX  = 32;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 3;

  // Rows left after one layer of 3:2 compressors: each full group of three
  // becomes two, leftovers pass straight through (equals ceil(2n/3)).
  function automatic int next_rows(input int n);
    return (n <= 2) ? n : 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int layers(input int n);
    int m;
    int l;
    m = n;
    l = 0;
    while (m > 2) begin
      m = next_rows(m);
      l++;
    end
    return l;
  endfunction

  function automatic int rows_at(input int n0, input int layer);
    int m;
    m = n0;
    for (int i = 0; i < layer; i++) m = next_rows(m);
    return m;
  endfunction

endpackage

// File: rtl/csa_row.sv
// N-bit 3:2 carry-save row: bitwise full adders, carry row left unshifted.
module csa_row #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] sum,
  output logic [N-1:0] cout
);

  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/wt_multiplier_pipe.sv
// Pipelined Wallace-tree multiplier, WIDTH x WIDTH -> 2*WIDTH, per-transaction
// signed/unsigned mode, 1..3 register ranks with a global stall.
module wt_multiplier_pipe
  import wt_multiplier_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 Signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 Busy
);

  localparam int P  = 2 * WIDTH;
  localparam int N0 = WIDTH + 1;
  localparam int NL = layers(N0);
  localparam int NG = (P + 3) / 4;

  // Handshake: a beat moves on valid & ready. A stalled output freezes every
  // rank (no bubble collapsing), so in_ready is simply the inverse of stall.
  logic stall, en, accept;
  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  logic [WIDTH-1:0] a0, b0;
  logic             s0, v0, rank0_busy;

  if (STAGES >= 3) begin : g_rank0
    always_ff @(posedge clk) begin
      if (rst) begin
        v0 <= 1'b0;
      end else if (en) begin
        v0 <= accept;
        a0 <= A;
        b0 <= B;
        s0 <= Signed;
      end
    end
    assign rank0_busy = v0;
  end else begin : g_no_rank0
    assign a0         = A;
    assign b0         = B;
    assign s0         = Signed;
    assign v0         = accept;
    assign rank0_busy = 1'b0;
  end

  // Baugh-Wooley: invert bits pairing exactly one operand MSB; the extra row
  // carries the +2^W and +2^(2W-1) corrections in signed mode.
  logic [P-1:0] pp [N0];
  always_comb begin
    for (int i = 0; i < N0; i++) pp[i] = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp[i][i+j] = (a0[j] & b0[i]) ^ (s0 & ((i == WIDTH - 1) != (j == WIDTH - 1)));
      end
    end
    if (s0 == MODE_SIGNED) begin
      pp[WIDTH][WIDTH] = 1'b1;
      pp[WIDTH][P-1]   = 1'b1;
    end
  end

  for (genvar l = 0; l <= NL; l++) begin : g_layer
    localparam int N = rows_at(N0, l);
    logic [P-1:0] r [N];
    if (l == 0) begin : g_init
      assign r = pp;
    end else begin : g_reduce
      localparam int M = rows_at(N0, l - 1);
      for (genvar g = 0; g < M / 3; g++) begin : g_csa
        logic [P-1:0] x, y, z;
        logic [P-2:0] sum_lo, cy;
        assign x = g_layer[l-1].r[3*g];
        assign y = g_layer[l-1].r[3*g+1];
        assign z = g_layer[l-1].r[3*g+2];
        // The top column needs only its sum; its carry would leave the product.
        csa_row #(.N(P - 1)) u_csa (
          .a    (x[P-2:0]),
          .b    (y[P-2:0]),
          .c    (z[P-2:0]),
          .sum  (sum_lo),
          .cout (cy)
        );
        assign r[2*g]   = {x[P-1] ^ y[P-1] ^ z[P-1], sum_lo};
        assign r[2*g+1] = {cy, 1'b0};
      end
      for (genvar k = 0; k < M % 3; k++) begin : g_pass
        assign r[2*(M/3)+k] = g_layer[l-1].r[3*(M/3)+k];
      end
    end
  end

  logic [P-1:0] row_s, row_c, s1, c1;
  logic         v1, rank1_busy;
  assign row_s = g_layer[NL].r[0];
  assign row_c = g_layer[NL].r[1];

  if (STAGES >= 2) begin : g_rank1
    always_ff @(posedge clk) begin
      if (rst) begin
        v1 <= 1'b0;
      end else if (en) begin
        v1 <= v0;
        s1 <= row_s;
        c1 <= row_c;
      end
    end
    assign rank1_busy = v1;
  end else begin : g_no_rank1
    assign s1         = row_s;
    assign c1         = row_c;
    assign v1         = v0;
    assign rank1_busy = 1'b0;
  end

  // Final adder: 4-bit carry-lookahead groups, rippled between groups.
  logic [4*NG-1:0] add_x, add_y, add_s;
  logic [NG-1:0]   gcin;
  assign add_x   = (4 * NG)'(s1);
  assign add_y   = (4 * NG)'(c1);
  assign gcin[0] = 1'b0;

  for (genvar g = 0; g < NG; g++) begin : g_cla
    logic [3:0] x, y, pg, c;
    logic [2:0] gg;
    assign x    = add_x[4*g +: 4];
    assign y    = add_y[4*g +: 4];
    assign pg   = x ^ y;
    assign gg   = x[2:0] & y[2:0];
    assign c[0] = gcin[g];
    assign c[1] = gg[0] | (pg[0] & c[0]);
    assign c[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & c[0]);
    assign c[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & c[0]);
    assign add_s[4*g +: 4] = pg ^ c;
    if (g < NG - 1) begin : g_cout
      assign gcin[g+1] = (x[3] & y[3]) | (pg[3] & c[3]);
    end
  end

  // Product keeps its last value while no new result arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Product   <= '0;
    end else if (en) begin
      out_valid <= v1;
      if (v1) Product <= add_s[P-1:0];
    end
  end

  assign Busy = out_valid | rank0_busy | rank1_busy;

endmodule

// File: tb/tb_wt_multiplier_pipe.sv
// Bench for wt_multiplier_pipe: directed table, streaming, backpressure and
// mid-flight reset on an 8x8/3-rank unit, plus 4x4/1-rank and 16x16/2-rank units.
module tb_wt_multiplier_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy, sgn = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic [15:0] product;

  logic        v4 = 1'b0, r4, ov4, busy4, s4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  p4;

  logic        v16 = 1'b0, r16, ov16, busy16, s16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] p16;

  wt_multiplier_pipe #(.WIDTH(8), .STAGES(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
    .Signed(sgn), .out_valid(out_valid), .out_ready(out_ready), .Product(product), .Busy(busy)
  );

  wt_multiplier_pipe #(.WIDTH(4), .STAGES(1)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .A(a4), .B(b4),
    .Signed(s4), .out_valid(ov4), .out_ready(1'b1), .Product(p4), .Busy(busy4)
  );

  wt_multiplier_pipe #(.WIDTH(16), .STAGES(2)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .A(a16), .B(b16),
    .Signed(s16), .out_valid(ov16), .out_ready(1'b1), .Product(p16), .Busy(busy16)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  bit chk_lat = 1'b1;
  logic [15:0] exp_q[$];
  int          cyc_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    bit          s;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Independent reference: sign-extend to 64 bits, multiply, keep 2w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input bit s, input int w);
    logic [63:0] xe, ye, mask;
    xe = 64'(x);
    ye = 64'(y);
    if (s && x[w-1]) xe = xe | (~64'd0 << w);
    if (s && y[w-1]) ye = ye | (~64'd0 << w);
    mask = (64'd1 << (2 * w)) - 64'd1;
    return (xe * ye) & mask;
  endfunction

  // One cycle on the 8x8 unit: drive at negedge, then score the handshakes
  // that the next rising edge will perform.
  task automatic step(input bit iv, input logic [7:0] ia, input logic [7:0] ib,
                      input bit is, input bit ordy, input logic [15:0] e);
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    sgn       = is;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_out: product %0h with nothing outstanding", product);
      end else begin
        check("product", product, exp_q.pop_front());
        if (chk_lat) check("latency", cyc - cyc_q.pop_front(), 3);
        else void'(cyc_q.pop_front());
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(e);
      cyc_q.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0);
  endtask

  initial begin
    logic [7:0] ta, tb;
    logic [3:0] xa, xb;
    logic [15:0] ra, rb;
    logic [7:0]  q4[$];
    logic [31:0] q16[$];
    int          c4[$];
    int          c16[$];

    vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[2]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    vecs[3]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    vecs[4]  = '{8'hFF, 8'h02, 1'b0, 16'h01FE};
    vecs[5]  = '{8'hFF, 8'h02, 1'b1, 16'hFFFE};
    vecs[6]  = '{8'h00, 8'hFF, 1'b1, 16'h0000};
    vecs[7]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    vecs[8]  = '{8'h7F, 8'h7F, 1'b0, 16'h3F01};
    vecs[9]  = '{8'h80, 8'hFF, 1'b1, 16'h0080};
    vecs[10] = '{8'h80, 8'hFF, 1'b0, 16'h7F80};
    vecs[11] = '{8'h0F, 8'h0F, 1'b0, 16'h00E1};
    vecs[12] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    vecs[13] = '{8'h12, 8'h34, 1'b0, 16'h03A8};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_product", product, 0);
    check("reset_in_ready", in_ready, 1);

    // Directed table, one transaction at a time
    for (int i = 0; i < 14; i++) begin
      step(1'b1, vecs[i].a, vecs[i].b, vecs[i].s, 1'b1, vecs[i].exp);
      idle(4);
    end

    // Back-to-back stream with alternating mode
    for (int k = 0; k < 16; k++) begin
      ta = (k < 2) ? 8'hFF : 8'(k * 37 + 5);
      tb = (k < 2) ? 8'h02 : 8'(k * 91 + 128);
      step(1'b1, ta, tb, k[0], 1'b1, 16'(ref_mul(32'(ta), 32'(tb), k[0], 8)));
      if (k == 10) begin
        check("stream_busy", busy, 1);
        check("stream_in_ready", in_ready, 1);
      end
    end
    idle(5);
    check("stream_drained", exp_q.size(), 0);

    // Backpressure: fill with out_ready low, hold 5 cycles, then drain
    chk_lat = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ta = 8'(8'hA0 + k);
      tb = 8'(8'hC3 - k * 7);
      step(1'b1, ta, tb, k[0], 1'b0, 16'(ref_mul(32'(ta), 32'(tb), k[0], 8)));
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'h55, 8'h66, 1'b0, 1'b0, 16'h2222);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_product_held", product, exp_q[0]);
    end
    idle(6);
    check("bp_drained", exp_q.size(), 0);
    chk_lat = 1'b1;

    // Reset with two transactions in flight
    step(1'b1, 8'h11, 8'h22, 1'b0, 1'b1, 16'h0242);
    step(1'b1, 8'hF0, 8'h0F, 1'b1, 1'b1, 16'hFF10);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_product", product, 0);
    exp_q.delete();
    cyc_q.delete();
    idle(6);

    // 4x4/1-rank exhaustive and 16x16/2-rank directed-pseudorandom, streamed
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      v4 = (k < 512);
      xa = 4'(k);
      xb = 4'(k >> 4);
      a4 = xa;
      b4 = xb;
      s4 = (k >= 256) && (k < 512);
      v16 = (k < 200);
      ra  = 16'($urandom_range(0, 65535));
      rb  = 16'($urandom_range(0, 65535));
      if (k < 4) begin
        ra = 16'h8000 >> (k * 15 / 3);
        rb = (k[0]) ? 16'hFFFF : 16'h8000;
      end
      a16 = ra;
      b16 = rb;
      s16 = 1'($urandom_range(0, 1));
      #1;
      if (ov4) begin
        if (q4.size() == 0) begin
          checks++;
          $display("FAIL w4_unexpected: product %0h", p4);
        end else begin
          check("w4_product", p4, q4.pop_front());
          check("w4_latency", k - c4.pop_front(), 1);
        end
      end
      if (ov16) begin
        if (q16.size() == 0) begin
          checks++;
          $display("FAIL w16_unexpected: product %0h", p16);
        end else begin
          check("w16_product", p16, q16.pop_front());
          check("w16_latency", k - c16.pop_front(), 2);
        end
      end
      if (v4 && r4) begin
        q4.push_back(8'(ref_mul(32'(a4), 32'(b4), s4, 4)));
        c4.push_back(k);
      end
      if (v16 && r16) begin
        q16.push_back(32'(ref_mul(32'(a16), 32'(b16), s16, 16)));
        c16.push_back(k);
      end
    end
    check("w4_drained", q4.size(), 0);
    check("w16_drained", q16.size(), 0);
    check("w4_idle_busy", busy4, 0);
    check("w16_idle_busy", busy16, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
